// File: rtl/arbitro_rr.sv
// arbitro_rr: round-robin grant of input FIFOs 0-3 onto output FIFOs 4-7 with burst limit and almost-full gating.
// Optional transfer counter output xfer_count when ARB_STATS_EN is defined.
module arbitro_rr #(
  parameter int BURST = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] fifo_empty,
  input  logic [3:0] out_almost_full,
  input  logic [1:0] dest,
  output logic [1:0] demux0,
  output logic [3:0] pop,
  output logic [3:0] push,
  output logic       active
`ifdef ARB_STATS_EN
  ,
  output logic [15:0] xfer_count
`endif
);
  typedef enum logic {IDLE, SERVE} state_t;
  state_t r_state, w_state_nxt;
  logic [1:0] r_demux0, w_pick;
  logic [3:0] r_burst_cnt;
  logic w_any, w_xfer, w_last;
  assign w_any  = ~&fifo_empty;
  assign w_xfer = !reset && r_state == SERVE && !fifo_empty[r_demux0] && !out_almost_full[dest];
  assign w_last = w_xfer && r_burst_cnt == 4'(BURST - 1);
  // Scan downward so the candidate nearest to demux0+1 wins; demux0 itself is last.
  always_comb begin
    w_pick = r_demux0;
    for (int k = 4; k >= 1; k--)
      if (!fifo_empty[r_demux0 + 2'(k)]) w_pick = r_demux0 + 2'(k);
  end
  always_ff @(posedge clk)
    if (reset) r_state <= IDLE;
    else r_state <= w_state_nxt;
  always_comb
    w_state_nxt = r_state == IDLE ? (w_any ? SERVE : IDLE)
                                  : ((fifo_empty[r_demux0] || w_last) ? IDLE : SERVE);
  always_ff @(posedge clk)
    if (reset) begin
      r_demux0    <= 2'b11;
      r_burst_cnt <= '0;
    end else begin
      if (r_state == IDLE && w_any) r_demux0 <= w_pick;
      r_burst_cnt <= (r_state == IDLE || w_state_nxt == IDLE) ? '0 : r_burst_cnt + 4'(w_xfer);
    end
  always_comb begin
    pop    = w_xfer ? 4'b0001 << r_demux0 : 4'b0000;
    push   = w_xfer ? 4'b0001 << dest : 4'b0000;
    active = r_state == SERVE;
  end
  assign demux0 = r_demux0;
`ifdef ARB_STATS_EN
  logic [15:0] r_xfer_count;
  always_ff @(posedge clk)
    if (reset) r_xfer_count <= '0;
    else if (w_xfer && r_xfer_count != 16'hFFFF) r_xfer_count <= r_xfer_count + 16'd1;
  assign xfer_count = r_xfer_count;
`endif
endmodule

// File: tb/tb_arbitro_rr.sv
// tb_arbitro_rr: randomized scoreboard bench for arbitro_rr against a queue-based arbitration model.
module tb_arbitro_rr;
  localparam int BURST = 4;
  logic clk = 0, reset = 1;
  logic [3:0] fifo_empty = 4'hF, out_almost_full = 0;
  logic [1:0] dest = 0, demux0;
  logic [3:0] pop, push;
  logic active;
  logic [15:0] xfer_count;
`ifdef ARB_STATS_EN
  arbitro_rr #(.BURST(BURST)) dut (.clk(clk), .reset(reset), .fifo_empty(fifo_empty),
    .out_almost_full(out_almost_full), .dest(dest), .demux0(demux0), .pop(pop), .push(push),
    .active(active), .xfer_count(xfer_count));
`else
  arbitro_rr #(.BURST(BURST)) dut (.clk(clk), .reset(reset), .fifo_empty(fifo_empty),
    .out_almost_full(out_almost_full), .dest(dest), .demux0(demux0), .pop(pop), .push(push),
    .active(active));
  assign xfer_count = '0;
`endif
  always #5 clk = ~clk;

  typedef struct {
    logic [1:0] d;
    logic [3:0] p, u;
    logic a;
    logic [15:0] c;
  } exp_t;
  exp_t sb[$];
  int compared = 0, mismatched = 0;

  // Bench-side FIFOs hold the destination of each queued word.
  int q0[$], q1[$], q2[$], q3[$];
  int m_grant = 3, m_moved = 0, m_stats = 0;
  bit m_serving = 0;

  function automatic int qsize(int i);
    return i == 0 ? q0.size() : i == 1 ? q1.size() : i == 2 ? q2.size() : q3.size();
  endfunction
  function automatic int qhead(int i);
    return i == 0 ? q0[0] : i == 1 ? q1[0] : i == 2 ? q2[0] : q3[0];
  endfunction
  task automatic qpop(int i);
    if (i == 0) void'(q0.pop_front());
    else if (i == 1) void'(q1.pop_front());
    else if (i == 2) void'(q2.pop_front());
    else void'(q3.pop_front());
  endtask
  task automatic load(int i, int n, int d);
    for (int k = 0; k < n; k++) begin
      int w = d < 0 ? int'($urandom_range(3)) : d;
      if (i == 0) q0.push_back(w);
      else if (i == 1) q1.push_back(w);
      else if (i == 2) q2.push_back(w);
      else q3.push_back(w);
    end
  endtask

  // One cycle: drive inputs, queue the expectation, then advance the model at the edge.
  task automatic step(input logic rst, input logic [3:0] oaf);
    exp_t e;
    bit xf, was_empty;
    int d;
    reset = rst;
    out_almost_full = oaf;
    for (int i = 0; i < 4; i++) fifo_empty[i] = qsize(i) == 0;
    d = qsize(m_grant) > 0 ? qhead(m_grant) : int'($urandom_range(3));
    dest = 2'(d);
    was_empty = qsize(m_grant) == 0;
    xf = !rst && m_serving && !was_empty && !oaf[d];
    e.d = 2'(m_grant);
    e.a = m_serving;
    e.p = xf ? 4'(1 << m_grant) : 4'd0;
    e.u = xf ? 4'(1 << d) : 4'd0;
    e.c = 16'(m_stats);
    sb.push_back(e);
    @(posedge clk);
    if (rst) begin
      m_grant = 3; m_serving = 0; m_moved = 0; m_stats = 0;
    end else if (!m_serving) begin
      for (int k = 1; k <= 4; k++)
        if (!m_serving && qsize((m_grant + k) % 4) > 0) begin
          m_grant = (m_grant + k) % 4;
          m_serving = 1;
          m_moved = 0;
        end
    end else begin
      if (xf) begin
        qpop(m_grant);
        m_moved++;
        if (m_stats < 65535) m_stats++;
      end
      if (was_empty || (xf && m_moved == BURST)) m_serving = 0;
    end
    #1;
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        compared++;
        if (demux0 !== e.d || pop !== e.p || push !== e.u || active !== e.a
`ifdef ARB_STATS_EN
            || xfer_count !== e.c
`endif
           ) begin
          mismatched++;
          $display("FAIL cycle_outputs t=%0t got demux0=%b pop=%b push=%b active=%b cnt=%h want demux0=%b pop=%b push=%b active=%b cnt=%h",
                   $time, demux0, pop, push, active, xfer_count, e.d, e.p, e.u, e.a, e.c);
        end
      end
    end
  end

  initial begin
    repeat (2) @(posedge clk);
    #1;
    step(1, 0);
    load(0, 10, 1);
    repeat (16) step(0, 0);
    for (int i = 0; i < 4; i++) load(i, 3, -1);
    repeat (40) step(0, 0);
    load(2, 5, 3);
    repeat (2) step(0, 0);
    repeat (5) step(0, 4'b1000);
    repeat (8) step(0, 0);
    load(1, 2, 0);
    load(3, 2, 2);
    repeat (10) step(0, 0);
    load(0, 6, 1);
    load(2, 2, 0);
    repeat (3) step(0, 0);
    step(1, 0);
    repeat (14) step(0, 0);
    for (int n = 0; n < 400; n++) begin
      for (int i = 0; i < 4; i++) if ($urandom_range(7) == 0) load(i, int'($urandom_range(1, 5)), -1);
      step($urandom_range(60) == 0, 4'($urandom_range(15) & $urandom_range(15)));
    end
`ifdef ARB_STATS_EN
    step(1, 0);
    for (int n = 0; n < 90000 && m_stats < 65535; n++) begin
      for (int i = 0; i < 4; i++) if (qsize(i) < 4) load(i, 4, -1);
      step(0, 0);
    end
    repeat (40) begin
      for (int i = 0; i < 4; i++) if (qsize(i) < 4) load(i, 4, -1);
      step(0, 0);
    end
`endif
    reset = 0;
    @(negedge clk);
    @(negedge clk);
    compared++;
    if (sb.size() != 0) begin
      mismatched++;
      $display("FAIL scoreboard_drain got %0d pending want 0", sb.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
